// File: rtl/barrel_shift_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and the
// payload carried from one pipeline level to the next.
package barrel_shift_pkg;

    // Payload fields are sized for the widest supported instance. A narrower
    // instance uses the low LENGTH / SH bits and keeps the upper bits at zero.
    localparam int unsigned MAX_LENGTH = 64;
    localparam int unsigned MAX_SH     = 6;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_op_t;

    typedef struct packed {
        logic [MAX_LENGTH-1:0] data;
        shift_op_t             op;
        logic [MAX_SH-1:0]     shamt;
    } level_payload_t;

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational level of the barrel shifter: shifts or rotates by
// 2**LEVEL when shamt bit LEVEL is set, otherwise passes the payload through.
module barrel_shift_level
    import barrel_shift_pkg::*;
#(
    parameter int unsigned LENGTH = 8,
    parameter int unsigned LEVEL  = 0
)
(
    input  level_payload_t in_p,
    output level_payload_t out_p
);

    localparam int unsigned AMT = 2 ** LEVEL;

    logic [LENGTH-1:0] d;
    logic [LENGTH-1:0] r;

    // Apply this level's fixed-distance shift; SRA fills from the current MSB,
    // which is still the original sign bit because earlier levels preserve it.
    always_comb begin
        d = in_p.data[LENGTH-1:0];
        r = d;
        if (in_p.shamt[LEVEL]) begin
            case (in_p.op)
                SLL:     r = d << AMT;
                SRL:     r = d >> AMT;
                SRA:     r = $signed(d) >>> AMT;
                ROL:     r = (d << AMT) | (d >> (LENGTH - AMT));
                default: r = d;
            endcase
        end
        out_p = in_p;
        out_p.data[LENGTH-1:0] = r;
    end

endmodule

// File: rtl/pipelined_barrel_shift.sv
// Pipelined barrel shifter: SH registered levels, each resolving one bit of
// the shift amount, with valid/ready flow control that collapses bubbles.
module pipelined_barrel_shift
    import barrel_shift_pkg::*;
#(
    parameter int unsigned LENGTH = 8
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LENGTH-1:0]          in_data,
    input  logic [$clog2(LENGTH)-1:0]  in_shamt,
    input  shift_op_t                  in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LENGTH-1:0]          out_data,
    output logic                       out_zero
);

    localparam int unsigned SH = $clog2(LENGTH);

    level_payload_t stage_in  [SH];
    level_payload_t stage_out [SH];
    level_payload_t stage_q   [SH];
    logic           valid_in  [SH];
    logic           valid_q   [SH];
    logic [SH:0]    load;
    logic           zero_q;

    // A level loads when empty or when the level after it moves on; the
    // virtual level past the end "loads" whenever the consumer is ready.
    always_comb begin
        load     = '0;
        load[SH] = out_ready;
        for (int i = SH - 1; i >= 0; i--) begin
            load[i] = !valid_q[i] || load[i+1];
        end
    end

    for (genvar k = 0; k < SH; k++) begin : g_level
        if (k == 0) begin : g_head
            // Widen the incoming operation into the shared payload format.
            always_comb begin
                stage_in[0]                  = '0;
                stage_in[0].data[LENGTH-1:0] = in_data;
                stage_in[0].op               = in_op;
                stage_in[0].shamt[SH-1:0]    = in_shamt;
                valid_in[0]                  = in_valid;
            end
        end else begin : g_body
            assign stage_in[k] = stage_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end

        barrel_shift_level #(
            .LENGTH (LENGTH),
            .LEVEL  (k)
        ) u_level (
            .in_p   (stage_in[k]),
            .out_p  (stage_out[k])
        );

        // Level register: payload and valid advance together on load.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q[k] <= 1'b0;
                stage_q[k] <= '0;
            end else if (load[k]) begin
                valid_q[k] <= valid_in[k];
                stage_q[k] <= stage_out[k];
            end
        end
    end

    // Zero flag registered alongside the final level so it tracks out_data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (load[SH-1]) begin
            zero_q <= (stage_out[SH-1].data[LENGTH-1:0] == '0);
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[SH-1];
    assign out_data  = stage_q[SH-1].data[LENGTH-1:0];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shift.sv
// Directed and scoreboarded checks for pipelined_barrel_shift at LENGTH = 8.
module tb_pipelined_barrel_shift;
    import barrel_shift_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    shift_op_t  in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    int n_assert;
    int n_fail;

    pipelined_barrel_shift #(.LENGTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] d,
                                             input logic [2:0] s);
        logic [15:0] dd;
        case (op)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 8'($signed(d) >>> s);
            default: begin
                dd = {d, d} << s;
                return dd[15:8];
            end
        endcase
    endfunction

    // One operation through an empty pipe with out_ready held high.
    task automatic run_one(input string tag, input shift_op_t op, input logic [7:0] d,
                           input logic [2:0] s, input logic [7:0] exp, input logic expz);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        tick();
        check({tag, "_lat2"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_zero"}, out_zero, expz);
        tick();
        check({tag, "_gone"}, out_valid, 0);
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_v;
    logic [7:0] burst_exp [16];
    int         n_acc;
    int         cyc;
    logic       acc_now;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SLL;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_zero", out_zero, 0);
        reset = 1'b1;
        tick();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);

        run_one("sll_a5_3", SLL, 8'hA5, 3'd3, 8'h28, 1'b0);
        run_one("sra_80_7", SRA, 8'h80, 3'd7, 8'hFF, 1'b0);
        run_one("srl_80_7", SRL, 8'h80, 3'd7, 8'h01, 1'b0);
        run_one("rol_81_1", ROL, 8'h81, 3'd1, 8'h03, 1'b0);
        run_one("sll_01_0", SLL, 8'h01, 3'd0, 8'h01, 1'b0);
        run_one("srl_0f_4", SRL, 8'h0F, 3'd4, 8'h00, 1'b1);
        run_one("sra_96_0", SRA, 8'h96, 3'd0, 8'h96, 1'b0);
        run_one("rol_5a_0", ROL, 8'h5A, 3'd0, 8'h5A, 1'b0);
        run_one("sra_70_2", SRA, 8'h70, 3'd2, 8'h1C, 1'b0);
        run_one("rol_f0_5", ROL, 8'hF0, 3'd5, 8'h1E, 1'b0);

        // Fill the pipe with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op = SLL; in_data = 8'h03; in_shamt = 3'd1;
        tick();
        in_op = SRL; in_data = 8'hF0; in_shamt = 3'd2;
        tick();
        in_op = ROL; in_data = 8'h80; in_shamt = 3'd1;
        tick();
        in_op = SLL; in_data = 8'hFF; in_shamt = 3'd7;
        #1;
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_out_data", out_data, 8'h06);
        tick();
        check("stall1_in_ready", in_ready, 0);
        check("stall1_out_valid", out_valid, 1);
        check("stall1_out_data", out_data, 8'h06);
        check("stall1_out_zero", out_zero, 0);
        tick();
        check("stall2_out_data", out_data, 8'h06);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("drain0_valid", out_valid, 1);
        check("drain0_data", out_data, 8'h06);
        tick();
        check("drain1_valid", out_valid, 1);
        check("drain1_data", out_data, 8'h3C);
        tick();
        check("drain2_valid", out_valid, 1);
        check("drain2_data", out_data, 8'h01);
        tick();
        check("drain3_empty", out_valid, 0);

        // Reset with two operations in flight.
        in_valid = 1'b1;
        in_op = SLL; in_data = 8'h11; in_shamt = 3'd1;
        tick();
        in_op = ROL; in_data = 8'h22; in_shamt = 3'd2;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_idle", out_valid, 0);
        run_one("sll_0f_4", SLL, 8'h0F, 3'd4, 8'hF0, 1'b0);

        // Back-to-back burst: one result per cycle once the pipe is full.
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_op    = shift_op_t'($urandom_range(0, 3));
                in_data  = 8'($urandom_range(0, 255));
                in_shamt = 3'($urandom_range(0, 7));
                burst_exp[i] = ref_shift(in_op, in_data, in_shamt);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 16) check("burst_in_ready", in_ready, 1);
            if (i >= 3) begin
                check("burst_out_valid", out_valid, 1);
                check("burst_out_data", out_data, burst_exp[i-3]);
            end else begin
                check("burst_fill_valid", out_valid, 0);
            end
            tick();
        end
        check("burst_end_empty", out_valid, 0);

        // Random stream with random backpressure against the reference model.
        n_acc    = 0;
        cyc      = 0;
        in_valid = 1'b1;
        in_op    = shift_op_t'($urandom_range(0, 3));
        in_data  = 8'($urandom_range(0, 255));
        in_shamt = 3'($urandom_range(0, 7));
        while (n_acc < 100 && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious", out_valid, 0);
                end else begin
                    exp_v = q.pop_front();
                    check("rand_data", out_data, exp_v);
                    check("rand_zero", out_zero, exp_v == 8'h00);
                end
            end
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                q.push_back(ref_shift(in_op, in_data, in_shamt));
                n_acc++;
            end
            tick();
            if (acc_now) begin
                in_op    = shift_op_t'($urandom_range(0, 3));
                in_data  = 8'($urandom_range(0, 255));
                in_shamt = 3'($urandom_range(0, 7));
            end
            if (n_acc >= 100) in_valid = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_accepted", n_acc, 100);

        out_ready = 1'b1;
        cyc       = 0;
        while (q.size() > 0 && cyc < 50) begin
            #1;
            if (out_valid) begin
                exp_v = q.pop_front();
                check("rand_drain_data", out_data, exp_v);
            end
            tick();
            cyc++;
        end
        check("rand_drained", q.size(), 0);
        check("rand_final_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shift.md
PIPELINED_BARREL_SHIFT -- requirements
Module: pipelined_barrel_shift

Interface
REQ-001 The block SHALL have parameter LENGTH, default 8, giving the data width; it must be a power of two, at least 2.
REQ-002 The block SHALL have local constant SH = $clog2(LENGTH), giving the shift-amount width and the pipeline depth.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the input operation is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 The block SHALL have port in_data, input, LENGTH bits: the operand.
REQ-008 The block SHALL have port in_shamt, input, SH bits: the shift amount, 0..LENGTH-1.
REQ-009 The block SHALL have port in_op, input, shift_op_t (2 bits): SLL=0, SRL=1, SRA=2, ROL=3.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_data, output, LENGTH bits: the result.
REQ-013 The block SHALL have port out_zero, output, 1 bit: out_data is all zeros.

Function
REQ-014 The block SHALL accept an input transfer on a rising clk edge where in_valid && in_ready; output transfers SHALL occur where out_valid && out_ready.
REQ-015 The block SHALL consist of SH registered levels; level k conditionally applies a shift or rotate of 2^k according to shamt bit k, and carries op, the remaining shamt bits and a valid bit.
REQ-016 The result SHALL be: SLL = data << shamt; SRL = data >> shamt (logical); SRA = arithmetic right shift, sign-filled from data[LENGTH-1]; ROL = rotate left by shamt.
REQ-017 Latency SHALL be exactly SH cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be one operation per cycle.
REQ-018 Level i SHALL load when it is empty or when level i+1 loads or drains in the same cycle; the last level drains on out_ready; in_ready SHALL equal the load condition of level 0.
REQ-019 in_ready SHALL be combinational from out_ready and the level valid bits only, never from in_valid.
REQ-020 While out_valid && !out_ready, out_data, out_zero and out_valid SHALL hold stable; bubbles in earlier levels SHALL collapse, so they do not stall.
REQ-021 in_shamt = 0 SHALL pass data unchanged for every op.
REQ-022 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-023 out_zero SHALL be registered with out_data, equal to (out_data == 0); it is don't-care when out_valid is low.

Reset
REQ-024 Assertion of reset (low) SHALL asynchronously clear all level valid bits, so out_valid = 0 and in_ready = 1 after release; out_data and out_zero SHALL reset to 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operations; the first transfer after release SHALL behave as from idle.

Structure
REQ-026 Package barrel_shift_pkg SHALL hold the shift_op_t enum and a level-payload struct (data, op, shamt); LENGTH stays a module parameter.
REQ-027 One sub-module, barrel_shift_level (parameters LENGTH, LEVEL), SHALL implement a single combinational 2^LEVEL stage; the top generates SH instances plus the valid/ready registers.

Verification
REQ-028 Reset, then LENGTH=8, SLL 8'hA5 by 3 with out_ready=1 -> out_data 8'h28 exactly 3 cycles later, out_zero=0.
REQ-029 SRA 8'h80 by 7 -> 8'hFF; SRL 8'h80 by 7 -> 8'h01; ROL 8'h81 by 1 -> 8'h03; SLL 8'h01 by 0 -> 8'h01.
REQ-030 Stream 100 random ops with in_valid=1 and random out_ready -> every result matches the reference model in order; a cycle-level check confirms one result per cycle when out_ready=1.
REQ-031 Fill the pipe (3 ops) with out_ready=0 -> in_ready=0 after the 3rd acceptance, out_data stable; raise out_ready -> 3 results in consecutive cycles.
REQ-032 Assert reset with 2 ops in flight -> out_valid=0 immediately; after release, a new SLL 8'h0F by 4 -> 8'hF0 with no stale output.
REQ-033 SRL 8'h0F by 4 -> out_data 8'h00, out_zero=1.
